// File: rtl/openmips_bus_pkg.sv
// Shared definitions for the OpenMIPS Wishbone bus bridges.
// Bus-state encoding, default data/address widths and the watchdog default limit.
package openmips_bus_pkg;

    localparam int unsigned RegBus            = 32;
    localparam int unsigned InstAddrBus       = 32;
    localparam int unsigned TimeoutCycDefault = 255;
    localparam int unsigned TimeoutCntW       = 16;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StBusy      = 2'd1,
        StWaitStall = 2'd2
    } bus_state_e;

endpackage

// File: rtl/wb_master_if.sv
// Bridges one OpenMIPS core memory port to a Wishbone classic master.
// Optional bus watchdog (TIMEOUT_CYC, bus_err_o) enabled by defining WB_TIMEOUT_EN.
module wb_master_if
    import openmips_bus_pkg::*;
#(
    parameter int unsigned ADDR_W      = InstAddrBus,
    parameter int unsigned DATA_W      = RegBus
`ifdef WB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = TimeoutCycDefault
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          stall_i,
    input  logic                flush_i,
    input  logic                cpu_ce_i,
    input  logic                cpu_we_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [DATA_W/8-1:0] cpu_sel_i,
    input  logic [DATA_W-1:0]   cpu_data_i,
    output logic [DATA_W-1:0]   cpu_data_o,
    output logic                stallreq_o,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    output logic                wb_we_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    output logic                wb_stb_o,
    output logic                wb_cyc_o,
    input  logic                wb_ack_i
`ifdef WB_TIMEOUT_EN
    ,
    output logic                bus_err_o
`endif
);

    bus_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   adr_q;
    logic [DATA_W-1:0]   dat_q;
    logic                we_q;
    logic [DATA_W/8-1:0] sel_q;
    logic                cyc_q;
    logic                stb_q;
    logic [DATA_W-1:0]   rd_buf_q;

    logic                stallreq;
    logic [DATA_W-1:0]   cpu_data;
    logic                load_req;
    logic                end_cyc;
    logic                load_buf;

`ifdef WB_TIMEOUT_EN
    localparam logic [TimeoutCntW-1:0] TimeoutLast = TimeoutCntW'(TIMEOUT_CYC - 1);

    logic [TimeoutCntW-1:0] cnt_q;
    logic                   timeout;

    // Fires in the TIMEOUT_CYC-th consecutive BUSY cycle without an ack.
    assign timeout = (state_q == StBusy) && !wb_ack_i && !flush_i && (cnt_q == TimeoutLast);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load_req) begin
            cnt_q <= '0;
        end else if (state_q == StBusy && !wb_ack_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus_err_o = timeout;
`endif

    always_comb begin
        state_d  = state_q;
        stallreq = 1'b0;
        cpu_data = '0;
        load_req = 1'b0;
        end_cyc  = 1'b0;
        load_buf = 1'b0;

        unique case (state_q)
            StIdle: begin
                stallreq = cpu_ce_i;
                if (cpu_ce_i) begin
                    load_req = 1'b1;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                if (wb_ack_i) begin
                    cpu_data = wb_dat_i;
                    end_cyc  = 1'b1;
                    load_buf = 1'b1;
                    state_d  = (|stall_i) ? StWaitStall : StIdle;
`ifdef WB_TIMEOUT_EN
                end else if (timeout) begin
                    end_cyc  = 1'b1;
                    state_d  = StIdle;
`endif
                end else begin
                    stallreq = 1'b1;
                end
            end
            StWaitStall: begin
                cpu_data = rd_buf_q;
                if (stall_i == 6'd0) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Flush wins in every state; a coincident ack is dropped.
        if (flush_i) begin
            state_d  = StIdle;
            stallreq = 1'b0;
            cpu_data = '0;
            load_req = 1'b0;
            load_buf = 1'b0;
            end_cyc  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            adr_q    <= '0;
            dat_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            rd_buf_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_req) begin
                adr_q <= cpu_addr_i;
                dat_q <= cpu_data_i;
                we_q  <= cpu_we_i;
                sel_q <= cpu_sel_i;
                cyc_q <= 1'b1;
                stb_q <= 1'b1;
            end else if (end_cyc) begin
                we_q  <= 1'b0;
                sel_q <= '0;
                cyc_q <= 1'b0;
                stb_q <= 1'b0;
            end
            if (load_buf) begin
                rd_buf_q <= wb_dat_i;
            end
        end
    end

    // Gate with reset so a request held during reset cannot raise a stall.
    assign stallreq_o = stallreq & rst;
    assign cpu_data_o = cpu_data;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign wb_we_o    = we_q;
    assign wb_sel_o   = sel_q;
    assign wb_stb_o   = stb_q;
    assign wb_cyc_o   = cyc_q;

endmodule

// File: tb/tb_wb_master_if.sv
// Directed bench for wb_master_if: reads, waited writes, stall hold, flush and async reset.
module tb_wb_master_if;
    import openmips_bus_pkg::*;

    logic        clk;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_ack_i;
`ifdef WB_TIMEOUT_EN
    logic        bus_err_o;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    wb_master_if #(
        .ADDR_W      (32),
        .DATA_W      (32)
`ifdef WB_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (8)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_sel_i  (cpu_sel_i),
        .cpu_data_i (cpu_data_i),
        .cpu_data_o (cpu_data_o),
        .stallreq_o (stallreq_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_stb_o   (wb_stb_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_ack_i   (wb_ack_i)
`ifdef WB_TIMEOUT_EN
        ,
        .bus_err_o  (bus_err_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b0;
        stall_i    = 6'd0;
        flush_i    = 1'b0;
        cpu_ce_i   = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0;
        cpu_sel_i  = 4'h0;
        cpu_data_i = 32'h0;
        wb_dat_i   = 32'h0;
        wb_ack_i   = 1'b0;
        #2;
        check("rst_cyc", 32'(wb_cyc_o), 32'd0);
        check("rst_stb", 32'(wb_stb_o), 32'd0);
        check("rst_we", 32'(wb_we_o), 32'd0);
        check("rst_adr", wb_adr_o, 32'h0);
        check("rst_stallreq", 32'(stallreq_o), 32'd0);
        check("rst_cpu_data", cpu_data_o, 32'h0);
        cpu_ce_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Zero-wait read
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0040; cpu_sel_i = 4'hF;
        #2;
        check("rd0_idle_stallreq", 32'(stallreq_o), 32'd1);
        tick();
        cpu_ce_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678;
        #2;
        check("rd0_cyc", 32'(wb_cyc_o), 32'd1);
        check("rd0_stb", 32'(wb_stb_o), 32'd1);
        check("rd0_adr", wb_adr_o, 32'h0000_0040);
        check("rd0_we", 32'(wb_we_o), 32'd0);
        check("rd0_ack_stallreq", 32'(stallreq_o), 32'd0);
        check("rd0_data", cpu_data_o, 32'h1234_5678);
        tick();
        wb_ack_i = 1'b0;
        #2;
        check("rd0_cyc_after", 32'(wb_cyc_o), 32'd0);
        check("rd0_idle_data", cpu_data_o, 32'h0);

        // Write with three wait states
        cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h0000_0080;
        cpu_data_i = 32'hDEAD_BEEF; cpu_sel_i = 4'b0011;
        #2;
        check("wr_idle_stallreq", 32'(stallreq_o), 32'd1);
        tick();
        cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_data_i = 32'h0; cpu_sel_i = 4'h0;
        for (int i = 0; i < 4; i++) begin
            wb_ack_i = (i == 3);
            #2;
            check("wr_we", 32'(wb_we_o), 32'd1);
            check("wr_sel", 32'(wb_sel_o), 32'h3);
            check("wr_dat", wb_dat_o, 32'hDEAD_BEEF);
            check("wr_cyc", 32'(wb_cyc_o), 32'd1);
            check("wr_stallreq", 32'(stallreq_o), (i == 3) ? 32'd0 : 32'd1);
            tick();
        end
        wb_ack_i = 1'b0;
        #2;
        check("wr_cyc_after", 32'(wb_cyc_o), 32'd0);
        check("wr_we_after", 32'(wb_we_o), 32'd0);
        check("wr_dat_held", wb_dat_o, 32'hDEAD_BEEF);

        // Read acked while the pipeline is stalled elsewhere
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0100; cpu_sel_i = 4'hF;
        tick();
        cpu_ce_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'hA5A5_0F0F; stall_i = 6'b000111;
        #2;
        check("rs_ack_data", cpu_data_o, 32'hA5A5_0F0F);
        tick();
        wb_dat_i = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            wb_ack_i = (i == 1);
            stall_i  = (i == 2) ? 6'd0 : 6'b000111;
            #2;
            check("rs_state", 32'(dut.state_q), 32'(StWaitStall));
            check("rs_hold_data", cpu_data_o, 32'hA5A5_0F0F);
            check("rs_stallreq", 32'(stallreq_o), 32'd0);
            tick();
            check("rs_no_restart", 32'(wb_cyc_o), 32'd0);
        end
        wb_ack_i = 1'b0;
        #2;
        check("rs_back_idle", 32'(dut.state_q), 32'(StIdle));
        check("rs_idle_data", cpu_data_o, 32'h0);

        // Flush in second BUSY cycle, late ack ignored
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0200;
        tick();
        cpu_ce_i = 1'b0;
        #2;
        check("fl_busy1_stallreq", 32'(stallreq_o), 32'd1);
        tick();
        flush_i = 1'b1;
        #2;
        check("fl_flush_stallreq", 32'(stallreq_o), 32'd0);
        check("fl_flush_cyc", 32'(wb_cyc_o), 32'd1);
        tick();
        flush_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h1111_2222;
        #2;
        check("fl_cyc", 32'(wb_cyc_o), 32'd0);
        check("fl_stb", 32'(wb_stb_o), 32'd0);
        check("fl_stallreq", 32'(stallreq_o), 32'd0);
        check("fl_late_ack_data", cpu_data_o, 32'h0);
        check("fl_state", 32'(dut.state_q), 32'(StIdle));
        tick();
        wb_ack_i = 1'b0;
        #2;
        check("fl_rd_buf", dut.rd_buf_q, 32'hA5A5_0F0F);
        check("fl_cyc_stays", 32'(wb_cyc_o), 32'd0);

        // Asynchronous reset in the middle of a write
        cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h0000_0300;
        cpu_data_i = 32'h0000_0055; cpu_sel_i = 4'hF;
        tick();
        cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
        #2;
        check("ar_busy_cyc", 32'(wb_cyc_o), 32'd1);
        rst = 1'b0;
        #1;
        check("ar_cyc", 32'(wb_cyc_o), 32'd0);
        check("ar_stb", 32'(wb_stb_o), 32'd0);
        check("ar_we", 32'(wb_we_o), 32'd0);
        check("ar_adr", wb_adr_o, 32'h0);
        check("ar_dat", wb_dat_o, 32'h0);
        check("ar_sel", 32'(wb_sel_o), 32'h0);
        check("ar_stallreq", 32'(stallreq_o), 32'd0);
        check("ar_cpu_data", cpu_data_o, 32'h0);
        rst = 1'b1;
        tick();
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0044; cpu_sel_i = 4'hF;
        tick();
        cpu_ce_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_F00D;
        #2;
        check("ar_restart_adr", wb_adr_o, 32'h0000_0044);
        check("ar_restart_we", 32'(wb_we_o), 32'd0);
        check("ar_restart_data", cpu_data_o, 32'hCAFE_F00D);
        tick();
        wb_ack_i = 1'b0;

`ifdef WB_TIMEOUT_EN
        // Slave never acks: watchdog aborts in the 8th BUSY cycle
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0400;
        tick();
        cpu_ce_i = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #2;
            check("to_bus_err", 32'(bus_err_o), (k == 8) ? 32'd1 : 32'd0);
            check("to_stallreq", 32'(stallreq_o), (k == 8) ? 32'd0 : 32'd1);
            check("to_cpu_data", cpu_data_o, 32'h0);
            tick();
        end
        #2;
        check("to_cyc_after", 32'(wb_cyc_o), 32'd0);
        check("to_err_after", 32'(bus_err_o), 32'd0);
        check("to_state_after", 32'(dut.state_q), 32'(StIdle));
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
